mem_lsu_hs: RTL and testbench
=============================

Name: mem_lsu_hs

Overview:
- Next-generation load/store unit for the MEM stage of the OpenMIPS-style five-stage pipeline.
- Replaces the zero-wait combinational data-RAM access with a request/acknowledge data-bus handshake of arbitrary latency.
- Stalls the pipeline while an access is in flight and detects misaligned addresses.
- Owns the LL/SC link bit internally and adds an optional bus-timeout watchdog.

Parameters:
- ADDR_W, 32, data-bus address width; effective address input is 32 bits, bus address uses the low ADDR_W bits.
- TIMEOUT_CYC, 255, watchdog limit in cycles, 1..65535; only used when the optional feature is compiled in.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- valid_i  in  1  MEM-stage instruction carries a memory op this cycle
- op_i  in  4  0=LB 1=LBU 2=LH 3=LHU 4=LW 5=SB 6=SH 7=SW 8=LL 9=SC, others = no access
- addr_i  in  32  effective address
- wdata_i  in  32  store data (rt value)
- flush_i  in  1  pipeline flush (exception/ERET)
- bus_req_o  out  1  bus request
- bus_we_o  out  1  bus write enable
- bus_addr_o  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- bus_sel_o  out  4  byte enables, big-endian (sel[3] = bits 31:24 = byte offset 0)
- bus_wdata_o  out  32  store data, lane-replicated
- bus_ack_i  in  1  bus completes the access this cycle; read data valid with it
- bus_rdata_i  in  32  read data
- bus_err_i  in  1  bus error, qualifies bus_ack_i
- stall_o  out  1  hold the pipeline upstream of MEM
- done_o  out  1  one-cycle pulse, result valid
- result_o  out  32  load result or SC status (1/0)
- exc_o  out  2  with done_o: 0=none 1=AdEL 2=AdES 3=bus error
- llbit_o  out  1  current link bit

Behaviour:
- Reset values:
  - bus_req_o, bus_we_o, done_o, llbit_o = 0
  - bus_addr_o, bus_sel_o, bus_wdata_o, result_o = 0
  - exc_o = 0
  - FSM in IDLE
- FSM states: IDLE, REQ, RESP, DRAIN.
- IDLE:
  - valid_i with op 0..9 and flush_i=0 is accepted.
  - Misalignment: LH/LHU/SH with addr[0]≠0, or LW/SW/LL/SC with addr[1:0]≠0 → RESP with exc = 1 (loads/LL/SC-load side) or 2 (SB/SH/SW/SC). No bus request is made.
  - SC with llbit=0 → RESP, result 0, no bus request.
  - Otherwise → REQ, latching addr, sel, we and wdata.
  - op 10..15 is ignored; stall_o=0 for it.
- REQ:
  - bus_req_o=1, all bus outputs held stable until bus_ack_i.
  - On ack: capture bus_rdata_i and extract the result, then go to RESP.
- RESP: done_o=1 for one cycle, result_o and exc_o valid, then IDLE.
- Minimum latency: accept → done = 2 cycles (ack in the first REQ cycle).
- stall_o = (IDLE & accepted) | REQ | DRAIN. stall_o is 0 in the RESP cycle.
- Load extraction: byte at offset k = rdata[31-8k -: 8]; halfword at offset 0 → [31:16], offset 2 → [15:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- Byte enables: byte ops use one-hot sel (offset 0→1000 … 3→0001); half ops use 1100 / 0011; word ops use 1111.
- Store data: SB replicates byte ×4, SH replicates half ×2, SW/SC pass wdata_i.
- Link bit:
  - Set to 1 when LL completes without error.
  - Cleared to 0 when any SC completes.
  - Cleared on flush_i.
  - Flush takes precedence if both occur in the same cycle.
- SC success: result 1 and the store is performed. SC failure: result 0.
- Bus error (ack with err): exc=3, result 0, link bit unchanged.
- flush_i:
  - In IDLE, discards valid_i.
  - In REQ, the request cannot be aborted: go to DRAIN, keep bus_req_o until ack, then IDLE with no done_o.
  - In RESP, suppresses done_o.
- Async reset mid-transaction drops bus_req_o immediately; the bus side must tolerate an abandoned request.

Optional Feature:
- Macro: MEM_LSU_TIMEOUT_EN.
- When defined, a 16-bit counter clears on entry to REQ/DRAIN and increments each cycle without ack.
  - On reaching TIMEOUT_CYC in REQ: drop bus_req_o, go to RESP with exc=3.
  - On reaching TIMEOUT_CYC in DRAIN: return to IDLE.
- When undefined, there is no counter and the FSM waits indefinitely for ack.

Test Plan:
- LB at addr 0x103, ack after 3 cycles with rdata 0x1122_33F0 → sel 0001, result 0xFFFF_FFF0, done 5 cycles after accept, stall high through REQ.
- SH at 0x202, wdata 0xAAAA_BEEF, immediate ack → bus_we=1, sel 0011, bus_wdata 0xBEEF_BEEF, done 2 cycles after accept.
- LW at 0x101 → no bus_req, done next cycle with exc=1; SW at 0x102 → exc=2.
- LL 0x40 → llbit=1; SC 0x40 → store sel 1111, result 1, llbit=0. Repeat SC → no bus_req, result 0.
- LW in REQ with flush_i pulse, ack 4 cycles later → bus_req held until ack, no done_o, llbit cleared, next valid_i accepted afterwards.
- With MEM_LSU_TIMEOUT_EN and TIMEOUT_CYC=8, no ack → bus_req drops after 8 cycles, done with exc=3; without the macro, bus_req stays high for 100 cycles.

Source files
------------

// File: rtl/mem_lsu_hs.sv
// MEM-stage load/store unit with a req/ack data-bus handshake, alignment checks and LL/SC link bit.
// Optional bus watchdog compiled in with `define MEM_LSU_TIMEOUT_EN.
module mem_lsu_hs #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [3:0]        op_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  input  logic              flush_i,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_sel_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic [31:0]       bus_rdata_i,
  input  logic              bus_err_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [31:0]       result_o,
  output logic [1:0]        exc_o,
  output logic              llbit_o,
  output logic [1:0]        state_o
);

  // Bus handshake: while bus_req_o is high, bus_we_o/addr/sel/wdata hold steady; the access
  // completes in the cycle bus_ack_i is high (rdata valid then), and bus_err_i only counts with ack.

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LBU = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LW  = 4'd4;
  localparam logic [3:0] OP_SB  = 4'd5;
  localparam logic [3:0] OP_SH  = 4'd6;
  localparam logic [3:0] OP_SW  = 4'd7;
  localparam logic [3:0] OP_LL  = 4'd8;
  localparam logic [3:0] OP_SC  = 4'd9;

  localparam logic [1:0] EXC_NONE = 2'd0;
  localparam logic [1:0] EXC_ADEL = 2'd1;
  localparam logic [1:0] EXC_ADES = 2'd2;
  localparam logic [1:0] EXC_BUS  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [3:0]  op_q;
  logic [1:0]  off_q;
  logic        llbit_q;
  logic        timeout;

  logic        accept, is_byte, is_half, is_word, is_store, misaligned, sc_fail;
  logic [3:0]  sel_d;
  logic [31:0] wdata_d;

  always_comb begin
    accept     = valid_i && !flush_i && (op_i <= OP_SC);
    is_byte    = (op_i == OP_LB) || (op_i == OP_LBU) || (op_i == OP_SB);
    is_half    = (op_i == OP_LH) || (op_i == OP_LHU) || (op_i == OP_SH);
    is_word    = (op_i == OP_LW) || (op_i == OP_SW) || (op_i == OP_LL) || (op_i == OP_SC);
    is_store   = (op_i == OP_SB) || (op_i == OP_SH) || (op_i == OP_SW) || (op_i == OP_SC);
    misaligned = (is_half && addr_i[0]) || (is_word && (addr_i[1:0] != 2'b00));
    sc_fail    = (op_i == OP_SC) && !llbit_q;
    sel_d      = 4'b1111;
    wdata_d    = wdata_i;
    if (is_byte) begin
      sel_d   = 4'b1000 >> addr_i[1:0];
      wdata_d = {4{wdata_i[7:0]}};
    end else if (is_half) begin
      sel_d   = addr_i[1] ? 4'b0011 : 4'b1100;
      wdata_d = {2{wdata_i[15:0]}};
    end
  end

  // Big-endian lane extraction: byte offset 0 lives in rdata[31:24].
  function automatic logic [31:0] load_extract(input logic [3:0] op, input logic [1:0] off,
                                               input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = rd[31:24];
      2'd1:    b = rd[23:16];
      2'd2:    b = rd[15:8];
      default: b = rd[7:0];
    endcase
    h = off[1] ? rd[15:0] : rd[31:16];
    case (op)
      OP_LB:        r = {{24{b[7]}}, b};
      OP_LBU:       r = {24'd0, b};
      OP_LH:        r = {{16{h[15]}}, h};
      OP_LHU:       r = {16'd0, h};
      OP_LW, OP_LL: r = rd;
      OP_SC:        r = 32'd1;
      default:      r = 32'd0;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = (misaligned || sc_fail) ? RESP : REQ;
      end
      REQ: begin
        if (flush_i)        state_d = bus_ack_i ? IDLE : DRAIN;
        else if (bus_ack_i) state_d = RESP;
        else if (timeout)   state_d = RESP;
      end
      RESP:    state_d = IDLE;
      DRAIN: begin
        if (bus_ack_i || timeout) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_req_o = (state_q == REQ) || (state_q == DRAIN);
    done_o    = (state_q == RESP) && !flush_i;
    stall_o   = ((state_q == IDLE) && accept) || (state_q == REQ) || (state_q == DRAIN);
    state_o   = state_q;
  end

`ifdef MEM_LSU_TIMEOUT_EN
  logic [15:0] to_cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      to_cnt <= '0;
    else if ((state_d != state_q) && ((state_d == REQ) || (state_d == DRAIN)))
      to_cnt <= '0;
    else if (((state_q == REQ) || (state_q == DRAIN)) && !bus_ack_i)
      to_cnt <= to_cnt + 16'd1;
  end
  assign timeout = ((state_q == REQ) || (state_q == DRAIN)) && !bus_ack_i &&
                   (to_cnt == 16'(TIMEOUT_CYC - 1));
`else
  logic [15:0] timeout_cfg_unused;
  assign timeout_cfg_unused = 16'(TIMEOUT_CYC);
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q        <= '0;
      off_q       <= '0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_sel_o   <= '0;
      bus_wdata_o <= '0;
      result_o    <= '0;
      exc_o       <= EXC_NONE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q     <= op_i;
            off_q    <= addr_i[1:0];
            result_o <= '0;
            exc_o    <= misaligned ? (is_store ? EXC_ADES : EXC_ADEL) : EXC_NONE;
            if (!misaligned && !sc_fail) begin
              bus_we_o    <= is_store;
              bus_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
              bus_sel_o   <= sel_d;
              bus_wdata_o <= wdata_d;
            end
          end
        end
        REQ: begin
          if (!flush_i && bus_ack_i) begin
            result_o <= bus_err_i ? 32'd0 : load_extract(op_q, off_q, bus_rdata_i);
            exc_o    <= bus_err_i ? EXC_BUS : EXC_NONE;
          end else if (!flush_i && timeout) begin
            result_o <= '0;
            exc_o    <= EXC_BUS;
          end
        end
        default: ;
      endcase
    end
  end

  // Flush wins over a completing LL/SC in the same cycle; bus errors leave the link untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      llbit_q <= 1'b0;
    else if (flush_i)
      llbit_q <= 1'b0;
    else if ((state_q == REQ) && bus_ack_i && !bus_err_i) begin
      if (op_q == OP_LL)      llbit_q <= 1'b1;
      else if (op_q == OP_SC) llbit_q <= 1'b0;
    end
  end

  assign llbit_o = llbit_q;

endmodule

// File: tb/tb_mem_lsu_hs.sv
// Directed self-checking bench for mem_lsu_hs; watchdog checks follow `define MEM_LSU_TIMEOUT_EN.
module tb_mem_lsu_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [3:0]  op_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        flush_i;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
  logic        bus_err_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [1:0]  exc_o;
  logic        llbit_o;
  logic [1:0]  state_o;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_lsu_hs #(.ADDR_W(32), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .op_i(op_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .flush_i(flush_i), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i),
    .stall_o(stall_o), .done_o(done_o), .result_o(result_o), .exc_o(exc_o),
    .llbit_o(llbit_o), .state_o(state_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] wd);
    valid_i = v;
    op_i    = op;
    addr_i  = a;
    wdata_i = wd;
  endtask

  task automatic bus(input logic ack, input logic err, input logic [31:0] rd);
    bus_ack_i   = ack;
    bus_err_i   = err;
    bus_rdata_i = rd;
  endtask

  // One accepted access with an ack in its first REQ cycle: accept, REQ, RESP.
  task automatic xfer(input string tag, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rd, input logic err,
                      input logic [3:0] exp_sel, input logic exp_we, input logic [31:0] exp_wd,
                      input logic [31:0] exp_res, input logic [1:0] exp_exc);
    cyc(); drive(1'b1, op, a, wd); settle();
    chk({tag, "_accept_stall"}, 32'(stall_o), 32'd1);
    cyc(); drive(1'b0, 4'd0, 32'd0, 32'd0); bus(1'b1, err, rd); settle();
    chk({tag, "_req"},   32'(bus_req_o), 32'd1);
    chk({tag, "_addr"},  bus_addr_o, a & 32'hFFFF_FFFC);
    chk({tag, "_sel"},   32'(bus_sel_o), 32'(exp_sel));
    chk({tag, "_we"},    32'(bus_we_o), 32'(exp_we));
    chk({tag, "_wdata"}, bus_wdata_o, exp_wd);
    cyc(); bus(1'b0, 1'b0, 32'd0); settle();
    chk({tag, "_done"},   32'(done_o), 32'd1);
    chk({tag, "_result"}, result_o, exp_res);
    chk({tag, "_exc"},    32'(exc_o), 32'(exp_exc));
    chk({tag, "_stall"},  32'(stall_o), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    flush_i = 1'b0;
    bus(1'b0, 1'b0, 32'd0);
    cyc(); cyc(); settle();
    chk("rst_req", 32'(bus_req_o), 32'd0);
    chk("rst_we", 32'(bus_we_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_llbit", 32'(llbit_o), 32'd0);
    chk("rst_addr", bus_addr_o, 32'd0);
    chk("rst_sel", 32'(bus_sel_o), 32'd0);
    chk("rst_wdata", bus_wdata_o, 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_exc", 32'(exc_o), 32'd0);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    rst = 1'b1;

    // LB at 0x103, ack after three wait cycles
    cyc(); drive(1'b1, 4'd0, 32'h103, 32'd0); settle();
    chk("lb_accept_stall", 32'(stall_o), 32'd1);
    chk("lb_accept_req", 32'(bus_req_o), 32'd0);
    cyc(); drive(1'b0, 4'd0, 32'd0, 32'd0); settle();
    chk("lb_req", 32'(bus_req_o), 32'd1);
    chk("lb_addr", bus_addr_o, 32'h100);
    chk("lb_sel", 32'(bus_sel_o), 32'h1);
    chk("lb_we", 32'(bus_we_o), 32'd0);
    for (int i = 0; i < 2; i++) begin
      cyc(); settle();
      chk("lb_wait_req", 32'(bus_req_o), 32'd1);
      chk("lb_wait_stall", 32'(stall_o), 32'd1);
      chk("lb_wait_done", 32'(done_o), 32'd0);
    end
    cyc(); bus(1'b1, 1'b0, 32'h1122_33F0); settle();
    chk("lb_ack_req", 32'(bus_req_o), 32'd1);
    cyc(); bus(1'b0, 1'b0, 32'd0); settle();
    chk("lb_done", 32'(done_o), 32'd1);
    chk("lb_result", result_o, 32'hFFFF_FFF0);
    chk("lb_exc", 32'(exc_o), 32'd0);
    chk("lb_resp_stall", 32'(stall_o), 32'd0);
    chk("lb_resp_req", 32'(bus_req_o), 32'd0);
    cyc(); settle();
    chk("lb_after_done", 32'(done_o), 32'd0);
    chk("lb_after_state", 32'(state_o), 32'd0);

    xfer("sh", 4'd6, 32'h202, 32'hAAAA_BEEF, 32'd0, 1'b0, 4'b0011, 1'b1, 32'hBEEF_BEEF,
         32'd0, 2'd0);
    xfer("lhu", 4'd3, 32'h102, 32'd0, 32'h1122_8899, 1'b0, 4'b0011, 1'b0, 32'd0,
         32'h0000_8899, 2'd0);
    xfer("lh", 4'd2, 32'h100, 32'd0, 32'h8001_0000, 1'b0, 4'b1100, 1'b0, 32'd0,
         32'hFFFF_8001, 2'd0);
    xfer("lbu", 4'd1, 32'h101, 32'd0, 32'h11AB_3344, 1'b0, 4'b0100, 1'b0, 32'd0,
         32'h0000_00AB, 2'd0);

    // Misaligned LW then SW: no bus request, exception next cycle
    cyc(); drive(1'b1, 4'd4, 32'h101, 32'd0); settle();
    chk("lw_mis_stall", 32'(stall_o), 32'd1);
    cyc(); drive(1'b0, 4'd0, 32'd0, 32'd0); settle();
    chk("lw_mis_req", 32'(bus_req_o), 32'd0);
    chk("lw_mis_done", 32'(done_o), 32'd1);
    chk("lw_mis_exc", 32'(exc_o), 32'd1);
    cyc(); drive(1'b1, 4'd7, 32'h102, 32'h1234_5678); settle();
    cyc(); drive(1'b0, 4'd0, 32'd0, 32'd0); settle();
    chk("sw_mis_req", 32'(bus_req_o), 32'd0);
    chk("sw_mis_done", 32'(done_o), 32'd1);
    chk("sw_mis_exc", 32'(exc_o), 32'd2);

    // LL / SB / bus error / SC / failing SC
    xfer("ll", 4'd8, 32'h40, 32'd0, 32'hCAFE_0001, 1'b0, 4'b1111, 1'b0, 32'd0,
         32'hCAFE_0001, 2'd0);
    chk("ll_llbit", 32'(llbit_o), 32'd1);
    xfer("sb", 4'd5, 32'h41, 32'h0000_005A, 32'd0, 1'b0, 4'b0100, 1'b1, 32'h5A5A_5A5A,
         32'd0, 2'd0);
    xfer("berr", 4'd4, 32'h80, 32'd0, 32'hDEAD_BEEF, 1'b1, 4'b1111, 1'b0, 32'd0,
         32'd0, 2'd3);
    chk("berr_llbit", 32'(llbit_o), 32'd1);
    xfer("sc_ok", 4'd9, 32'h40, 32'h1234_5678, 32'd0, 1'b0, 4'b1111, 1'b1, 32'h1234_5678,
         32'd1, 2'd0);
    chk("sc_ok_llbit", 32'(llbit_o), 32'd0);
    cyc(); drive(1'b1, 4'd9, 32'h40, 32'h1234_5678); settle();
    chk("sc_fail_stall", 32'(stall_o), 32'd1);
    cyc(); drive(1'b0, 4'd0, 32'd0, 32'd0); settle();
    chk("sc_fail_req", 32'(bus_req_o), 32'd0);
    chk("sc_fail_done", 32'(done_o), 32'd1);
    chk("sc_fail_result", result_o, 32'd0);
    chk("sc_fail_exc", 32'(exc_o), 32'd0);

    // Flush while in REQ: drain until ack, no done, link cleared
    xfer("ll2", 4'd8, 32'h40, 32'd0, 32'h0000_0077, 1'b0, 4'b1111, 1'b0, 32'd0,
         32'h0000_0077, 2'd0);
    cyc(); drive(1'b1, 4'd4, 32'h300, 32'd0); settle();
    cyc(); drive(1'b0, 4'd0, 32'd0, 32'd0); flush_i = 1'b1; settle();
    chk("fl_req", 32'(bus_req_o), 32'd1);
    chk("fl_stall", 32'(stall_o), 32'd1);
    cyc(); flush_i = 1'b0; settle();
    chk("fl_state", 32'(state_o), 32'd3);
    chk("fl_drain_req", 32'(bus_req_o), 32'd1);
    chk("fl_drain_stall", 32'(stall_o), 32'd1);
    chk("fl_llbit", 32'(llbit_o), 32'd0);
    for (int i = 0; i < 2; i++) begin
      cyc(); settle();
      chk("fl_hold_req", 32'(bus_req_o), 32'd1);
      chk("fl_hold_done", 32'(done_o), 32'd0);
    end
    cyc(); bus(1'b1, 1'b0, 32'h0000_0055); settle();
    chk("fl_ack_req", 32'(bus_req_o), 32'd1);
    cyc(); bus(1'b0, 1'b0, 32'd0); settle();
    chk("fl_end_state", 32'(state_o), 32'd0);
    chk("fl_end_req", 32'(bus_req_o), 32'd0);
    chk("fl_end_done", 32'(done_o), 32'd0);
    chk("fl_end_stall", 32'(stall_o), 32'd0);
    xfer("fl_next", 4'd1, 32'h303, 32'd0, 32'h0000_00C3, 1'b0, 4'b0001, 1'b0, 32'd0,
         32'h0000_00C3, 2'd0);

    // Flush in RESP suppresses done
    cyc(); drive(1'b1, 4'd4, 32'h101, 32'd0); settle();
    cyc(); drive(1'b0, 4'd0, 32'd0, 32'd0); flush_i = 1'b1; settle();
    chk("flresp_state", 32'(state_o), 32'd2);
    chk("flresp_done", 32'(done_o), 32'd0);
    cyc(); flush_i = 1'b0; settle();
    chk("flresp_idle", 32'(state_o), 32'd0);

    // Flush in IDLE discards valid_i; op 12 is ignored
    cyc(); drive(1'b1, 4'd4, 32'h100, 32'd0); flush_i = 1'b1; settle();
    chk("flidle_stall", 32'(stall_o), 32'd0);
    cyc(); drive(1'b0, 4'd0, 32'd0, 32'd0); flush_i = 1'b0; settle();
    chk("flidle_req", 32'(bus_req_o), 32'd0);
    chk("flidle_done", 32'(done_o), 32'd0);
    cyc(); drive(1'b1, 4'd12, 32'h100, 32'd0); settle();
    chk("op12_stall", 32'(stall_o), 32'd0);
    cyc(); drive(1'b0, 4'd0, 32'd0, 32'd0); settle();
    chk("op12_state", 32'(state_o), 32'd0);
    chk("op12_req", 32'(bus_req_o), 32'd0);

    // No ack: watchdog trips after 8 cycles, or the request waits indefinitely
    cyc(); drive(1'b1, 4'd4, 32'h500, 32'd0); settle();
    cyc(); drive(1'b0, 4'd0, 32'd0, 32'd0); settle();
`ifdef MEM_LSU_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      chk("to_req_held", 32'(bus_req_o), 32'd1);
      cyc(); settle();
    end
    chk("to_req_drop", 32'(bus_req_o), 32'd0);
    chk("to_done", 32'(done_o), 32'd1);
    chk("to_exc", 32'(exc_o), 32'd3);
    chk("to_result", result_o, 32'd0);
`else
    for (int i = 0; i < 100; i++) begin
      chk("nto_req_held", 32'(bus_req_o), 32'd1);
      cyc(); settle();
    end
    bus(1'b1, 1'b0, 32'h0102_0304); settle();
    chk("nto_ack_req", 32'(bus_req_o), 32'd1);
    cyc(); bus(1'b0, 1'b0, 32'd0); settle();
    chk("nto_done", 32'(done_o), 32'd1);
    chk("nto_result", result_o, 32'h0102_0304);
    chk("nto_exc", 32'(exc_o), 32'd0);
`endif

    // Asynchronous reset mid-transaction drops the request at once
    cyc(); drive(1'b1, 4'd4, 32'h600, 32'd0); settle();
    cyc(); drive(1'b0, 4'd0, 32'd0, 32'd0); settle();
    chk("arst_pre_req", 32'(bus_req_o), 32'd1);
    rst = 1'b0;
    #1;
    chk("arst_req", 32'(bus_req_o), 32'd0);
    chk("arst_state", 32'(state_o), 32'd0);
    chk("arst_addr", bus_addr_o, 32'd0);
    cyc(); rst = 1'b1;
    cyc(); settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
